// File: rtl/rr_mux41_if.sv
// Stream bundle for the 4:1 round-robin mux: four producer channels in, one tagged word out.
// master = producers/consumer side, slave = the mux itself.
interface rr_mux41_if #(
  parameter int unsigned WIDTH = 8
);
  logic [3:0]         in_valid;
  logic [4*WIDTH-1:0] in_data;
  logic [3:0]         in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [1:0]         out_sel;
  logic               out_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_sel,
    output out_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    output out_sel,
    input  out_ready
  );
endinterface

// File: rtl/rr_mux41.sv
// Four-channel arbitrating mux with a registered, source-tagged output stage.
// RR_MUX41_ROUNDROBIN_EN selects round-robin; otherwise fixed priority (channel 0 highest).
module rr_mux41 #(
  parameter int unsigned WIDTH = 8
) (
  input logic       clk,
  input logic       rst,
  rr_mux41_if.slave bus
);

  logic             load;
  logic             grant_valid;
  logic [1:0]       grant;
  logic             xfer;
  logic [1:0]       search_base;
  logic [WIDTH-1:0] grant_data;
  logic [3:0]       in_ready;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]       out_sel_q, out_sel_d;

  assign load = ~out_valid_q | bus.out_ready;
  assign xfer = load & grant_valid;

`ifdef RR_MUX41_ROUNDROBIN_EN
  logic [1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = grant + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 2'd0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign search_base = ptr_q;
`else
  assign search_base = 2'd0;
`endif

  // First valid channel at or above search_base, wrapping modulo 4.
  always_comb begin : arb
    logic [1:0] idx;
    idx         = 2'd0;
    grant_valid = 1'b0;
    grant       = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = search_base + 2'(i);
      if (!grant_valid && bus.in_valid[idx]) begin
        grant_valid = 1'b1;
        grant       = idx;
      end
    end
  end

  always_comb begin
    grant_data = '0;
    unique case (grant)
      2'd0: grant_data = bus.in_data[0*WIDTH +: WIDTH];
      2'd1: grant_data = bus.in_data[1*WIDTH +: WIDTH];
      2'd2: grant_data = bus.in_data[2*WIDTH +: WIDTH];
      2'd3: grant_data = bus.in_data[3*WIDTH +: WIDTH];
      default: grant_data = '0;
    endcase
  end

  always_comb begin
    in_ready = 4'b0000;
    if (xfer) begin
      in_ready[grant] = 1'b1;
    end
  end

  // Drain without refill clears valid but keeps data/sel as last emitted.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data;
      out_sel_d   = grant;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 2'd0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

  a_ready_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(bus.in_ready));
  a_ready_valid  : assert property (@(posedge clk) disable iff (rst)
                                    (bus.in_ready & ~bus.in_valid) == 4'b0000);
  a_hold_stall   : assert property (@(posedge clk) disable iff (rst)
                                    (bus.out_valid && !bus.out_ready) |-> bus.in_ready == 4'b0000);

endmodule
